// File: rtl/monitor_dbg_clock_pkg.sv
// Shared register map, bit positions and FSM encoding for the monitor debug-clock generator.
package monitor_dbg_clock_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STEP   = 3'd1;
    localparam logic [2:0] ADDR_HALF   = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_COUNT  = 3'd4;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_STOP   = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_CLK  = 1;
    localparam int STAT_DONE = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } dbg_state_e;

endpackage

// File: rtl/monitor_dbg_clock_phase.sv
// Phase timer: load arms it with HALF-1, it counts down while enabled and flags the last cycle of a phase.
module monitor_dbg_clock_phase #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] half,
    output logic         tc
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] ph;

    always_ff @(posedge clk) begin
        if (reset) begin
            ph <= '0;
        end else if (load) begin
            ph <= half - ONE;
        end else if (en && (ph != '0)) begin
            ph <= ph - ONE;
        end
    end

    assign tc = en && (ph == '0);

endmodule

// File: rtl/monitor_dbg_clock_ctrl.sv
// Avalon-MM debug clock generator: stop, single-step N cycles or free-run at a programmable half-period.
module monitor_dbg_clock_ctrl
    import monitor_dbg_clock_pkg::*;
#(
    parameter int HALF_DEFAULT = 4,
    parameter int CNT_W        = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        dbg_clk_out,
    output logic        irq
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    dbg_state_e       state;
    logic             run, irq_en, done, stop_pend, step_mode;
    logic [CNT_W-1:0] half, remaining, count;
    logic [CNT_W-1:0] wdata_c;
    logic             wr_ctrl, wr_step, wr_half, wr_status, wr_count;
    logic             tc, step_ok, start, finish, phase_load;
    logic [31:0]      rd_mux;

    // Avalon slave without waitrequest: a write strobe is accepted in the cycle it is
    // high, and readdata always reflects the address of the previous cycle.
    always_comb begin
        wdata_c    = CNT_W'(writedata);
        wr_ctrl    = write && (address == ADDR_CTRL);
        wr_step    = write && (address == ADDR_STEP);
        wr_half    = write && (address == ADDR_HALF);
        wr_status  = write && (address == ADDR_STATUS);
        wr_count   = write && (address == ADDR_COUNT);
        step_ok    = wr_step && (state == IDLE) && !run && (wdata_c != '0);
        start      = (state == IDLE) && (run || step_ok);
        finish     = (state == LOW) && tc && (stop_pend || (!run && (remaining == '0)));
        phase_load = start || tc;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_CTRL: begin
                rd_mux[CTRL_RUN]    = run;
                rd_mux[CTRL_IRQ_EN] = irq_en;
            end
            ADDR_STEP:  rd_mux = 32'(remaining);
            ADDR_HALF:  rd_mux = 32'(half);
            ADDR_STATUS: begin
                rd_mux[STAT_BUSY] = (state != IDLE);
                rd_mux[STAT_CLK]  = dbg_clk_out;
                rd_mux[STAT_DONE] = done;
            end
            ADDR_COUNT: rd_mux = 32'(count);
            default:    rd_mux = '0;
        endcase
    end

    monitor_dbg_clock_phase #(.W(CNT_W)) u_phase (
        .clk   (clk),
        .reset (reset),
        .load  (phase_load),
        .en    (state != IDLE),
        .half  (half),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            dbg_clk_out <= 1'b0;
            readdata    <= '0;
            irq         <= 1'b0;
            run         <= 1'b0;
            irq_en      <= 1'b0;
            done        <= 1'b0;
            stop_pend   <= 1'b0;
            step_mode   <= 1'b0;
            remaining   <= '0;
            count       <= '0;
            half        <= CNT_W'(HALF_DEFAULT);
        end else begin
            if (wr_ctrl) begin
                run    <= writedata[CTRL_RUN];
                irq_en <= writedata[CTRL_IRQ_EN];
            end
            if (wr_half) half <= (wdata_c == '0) ? ONE : wdata_c;
            if (wr_ctrl && writedata[CTRL_STOP] && (state != IDLE)) stop_pend <= 1'b1;

            case (state)
                IDLE: if (start) begin
                    state       <= HIGH;
                    dbg_clk_out <= 1'b1;
                    count       <= count + ONE;
                    step_mode   <= step_ok;
                    if (step_ok) remaining <= wdata_c - ONE;
                end
                HIGH: if (tc) begin
                    state       <= LOW;
                    dbg_clk_out <= 1'b0;
                end
                LOW: if (tc) begin
                    if (finish) begin
                        state     <= IDLE;
                        stop_pend <= 1'b0;
                    end else begin
                        state       <= HIGH;
                        dbg_clk_out <= 1'b1;
                        count       <= count + ONE;
                        if (step_mode && (remaining != '0)) remaining <= remaining - ONE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Later assignments take priority: COUNT clear beats increment, DONE set beats clear.
            if (wr_count) count <= '0;
            if (wr_status && writedata[STAT_DONE]) done <= 1'b0;
            if (finish && (step_mode || stop_pend)) done <= 1'b1;

            irq      <= done & irq_en;
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_monitor_dbg_clock_ctrl.sv
// Directed bench for the debug clock generator with an expected-value queue and assertion checks.
module tb_monitor_dbg_clock_ctrl;
    import monitor_dbg_clock_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        dbg_clk_out;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    int          edges;
    logic        prev;
    int          guard;
    logic [31:0] v;

    monitor_dbg_clock_ctrl #(.HALF_DEFAULT(4), .CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .write       (write),
        .writedata   (writedata),
        .readdata    (readdata),
        .dbg_clk_out (dbg_clk_out),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_next(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed %0h expected <queue empty>", tag, obs);
        end else begin
            check(tag, obs, exp_q.pop_front());
        end
    endtask

    // All tasks start and end at a falling edge.
    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
        address   = 3'd0;
        writedata = '0;
    endtask

    task automatic do_read(input logic [2:0] a, input logic [31:0] e, input string tag);
        exp_q.push_back(e);
        address = a;
        @(negedge clk);
        expect_next(tag, readdata);
    endtask

    task automatic peek(input logic [2:0] a, output logic [31:0] val);
        address = a;
        @(negedge clk);
        val = readdata;
    endtask

    initial begin
        reset = 1'b1; address = '0; write = 1'b0; writedata = '0;
        repeat (3) @(negedge clk);
        check("rst_out", {31'd0, dbg_clk_out}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_readdata", readdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        for (int a = 0; a < 8; a++)
            do_read(3'(a), (a == 2) ? 32'd4 : 32'd0, $sformatf("reset_read_a%0d", a));

        // Three-pulse step burst at HALF=2
        do_write(ADDR_HALF, 32'd2);
        do_write(ADDR_STEP, 32'd3);
        for (int i = 0; i < 16; i++)
            exp_q.push_back(((i < 12) && ((i % 4) < 2)) ? 32'd1 : 32'd0);
        for (int i = 0; i < 16; i++) begin
            expect_next($sformatf("step_wave_%0d", i), {31'd0, dbg_clk_out});
            @(negedge clk);
        end
        do_read(ADDR_COUNT, 32'd3, "step_count");
        do_read(ADDR_STEP, 32'd0, "step_remaining");
        do_read(ADDR_STATUS, 32'd4, "step_status");

        // Interrupt on single-step completion
        do_write(ADDR_STATUS, 32'd4);
        do_write(ADDR_CTRL, 32'd4);
        do_write(ADDR_STEP, 32'd1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("irq_rise_%0d", i), {31'd0, irq}, (i >= 5) ? 32'd1 : 32'd0);
            if (i < 5) @(negedge clk);
        end
        do_write(ADDR_STATUS, 32'd4);
        check("irq_hold", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("irq_clear", {31'd0, irq}, 32'd0);

        // Free run at HALF=1, then STOP while high
        do_write(ADDR_HALF, 32'd1);
        do_write(ADDR_COUNT, 32'd0);
        do_write(ADDR_CTRL, 32'd1);
        edges = 0; prev = 1'b0;
        for (int n = 0; n < 8; n++) begin
            check($sformatf("run_wave_%0d", n), {31'd0, dbg_clk_out}, 32'(n % 2));
            if (dbg_clk_out && !prev) edges++;
            prev = dbg_clk_out;
            if (n < 7) @(negedge clk);
        end
        do_write(ADDR_CTRL, 32'd2);
        check("stop_low", {31'd0, dbg_clk_out}, 32'd0);
        @(negedge clk);
        check("stop_idle_out", {31'd0, dbg_clk_out}, 32'd0);
        do_read(ADDR_STATUS, 32'd4, "stop_status");
        do_read(ADDR_COUNT, 32'(edges), "run_count");

        // Ignored STEP writes and HALF=0 coercion
        do_write(ADDR_STATUS, 32'd4);
        do_write(ADDR_HALF, 32'd2);
        do_write(ADDR_COUNT, 32'd0);
        do_write(ADDR_STEP, 32'd3);
        do_write(ADDR_STEP, 32'd5);
        do_read(ADDR_STEP, 32'd2, "busy_step_ignored");
        guard = 0;
        do begin
            peek(ADDR_STATUS, v);
            guard++;
        end while (v[STAT_BUSY] && (guard < 100));
        check("idle_timeout", {31'd0, v[STAT_BUSY]}, 32'd0);
        do_read(ADDR_STEP, 32'd0, "burst_remaining");
        do_read(ADDR_COUNT, 32'd3, "burst_count");
        do_write(ADDR_STEP, 32'd0);
        do_read(ADDR_STATUS, 32'd4, "step0_ignored");
        do_write(ADDR_HALF, 32'd0);
        do_read(ADDR_HALF, 32'd1, "half0_coerced");

        // Reset in the middle of a burst
        do_write(ADDR_STEP, 32'd10);
        edges = 0; prev = 1'b0; guard = 0;
        while ((edges < 3) && (guard < 60)) begin
            if (dbg_clk_out && !prev) edges++;
            prev = dbg_clk_out;
            if (edges < 3) begin
                @(negedge clk);
                guard++;
            end
        end
        check("reset_edges", 32'(edges), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_out", {31'd0, dbg_clk_out}, 32'd0);
        check("midreset_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        do_read(ADDR_STATUS, 32'd0, "midreset_status");
        do_read(ADDR_COUNT, 32'd0, "midreset_count");
        do_read(ADDR_STEP, 32'd0, "midreset_step");
        do_read(ADDR_HALF, 32'd4, "midreset_half");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/monitor_dbg_clock_ctrl.md
Name: monitor_dbg_clock_ctrl

Overview:
Avalon-MM-controlled generator for the debug clock that the monitor's dbg_clock input port samples. Software can stop the clock, single-step it N cycles, or free-run it at a programmable half-period. It counts the rising edges it generates and can raise an interrupt when a step burst completes. It sits on the monitor's Avalon bus, alongside the PIO that reads the clock back.

Parameters:
HALF_DEFAULT, 4, reset value of HALF register (clk cycles per dbg clock phase)
CNT_W, 32, width of edge counter and step counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  3  register select
write  in  1  write strobe, one cycle
writedata  in  32  write data
readdata  out  32  registered read data, updated every cycle
dbg_clk_out  out  1  generated debug clock
irq  out  1  done interrupt, level

Behaviour:
- Reset, synchronous active-high:
  - dbg_clk_out=0, readdata=0, irq=0
  - state IDLE; RUN=0, IRQ_EN=0, DONE=0
  - STEP remaining=0, COUNT=0, HALF=HALF_DEFAULT
  - Reset mid-burst aborts immediately; the output is forced low the next cycle.
- Registers (readdata = mux(address), registered, 1-cycle latency, no read strobe):
  - 0 CTRL: bit0 RUN (rw); bit1 STOP (write-1 pulse, reads 0); bit2 IRQ_EN (rw).
  - 1 STEP: write N starts an N-cycle burst if IDLE and RUN=0. Ignored if busy or N=0. Read returns remaining cycles.
  - 2 HALF: write 0 is coerced to 1. New value takes effect at the next phase reload, never mid-phase.
  - 3 STATUS (ro except DONE): bit0 busy (state!=IDLE); bit1 dbg_clk_out; bit2 DONE, sticky, cleared by writing 1 to bit2.
  - 4 COUNT: rising edges generated, wraps mod 2^CNT_W. Any write clears it.
  - Addresses 5-7 read 0; writes to them are ignored.
- FSM with states IDLE, HIGH, LOW; phase counter ph.
  - IDLE: out=0. If RUN=1 or a valid STEP write arrives: out←1, ph←HALF-1, goto HIGH, COUNT++, and (step mode) remaining--.
  - HIGH: ph--. When ph==0: out←0, ph←HALF-1, goto LOW.
  - LOW: ph--. When ph==0:
    - If stop_pend, or (RUN=0 and remaining==0): goto IDLE, DONE←1 (step mode or stop), clear stop_pend.
    - Otherwise: out←1, ph←HALF-1, goto HIGH, COUNT++, remaining-- if step mode.
- Each phase therefore lasts exactly HALF clk cycles, giving a period of 2*HALF. With HALF=1, out toggles every clk.
- STOP sets stop_pend. The current HIGH+LOW pair always completes, so no runt pulses. STOP in IDLE is a no-op.
- Clearing RUN while running and with remaining=0 ends at the end of the current LOW, with the same rule as STOP. DONE is set only if a burst or STOP ended.
- Simultaneous events:
  - DONE set and DONE-clear write in the same cycle: set wins.
  - COUNT++ and COUNT write in the same cycle: clear wins.
  - Read of a register written in the same cycle returns the old value.
- irq = DONE & IRQ_EN, registered.

Decomposition:
- Package monitor_dbg_clock_pkg holds:
  - register address constants (ADDR_CTRL..ADDR_COUNT)
  - CTRL/STATUS bit indices
  - FSM state encoding (IDLE=2'd0, HIGH=2'd1, LOW=2'd2)
- One sub-module, monitor_dbg_clock_phase: the phase timer. It takes load, HALF, and en, and outputs a terminal-count pulse.
- The register file and FSM stay in the top level.

Test Plan:
- Reset then read all addresses → HALF=4, everything else 0; dbg_clk_out=0, irq=0.
- HALF=2, STEP=3 → exactly 3 pulses, each 2 high / 2 low clk cycles. Then COUNT=3, STEP reads 0, DONE=1, busy=0.
- IRQ_EN=1, STEP=1 → irq rises 1 cycle after DONE sets. Writing STATUS bit2=1 clears irq the next cycle.
- RUN=1, HALF=1 → out toggles every clk. Write STOP during HIGH → the current pulse completes, then IDLE with DONE=1. COUNT equals the number of rising edges seen.
- STEP=5 while busy, and STEP=0 in IDLE → both ignored. HALF=0 → reads back 1.
- Assert reset mid-burst (STEP=10 after 3 edges) → next cycle out=0, state IDLE, COUNT=0, STEP=0.
